udp_send: RTL and testbench
===========================

// Module: udp_send
// PURPOSE
// Downstream neighbour of sdr_send in the 100 Mbit/s Ethernet transmit path. It accepts a payload
// request (length, port_ID, byte stream) and prepends the 8-byte UDP header. It then forwards the
// header and payload to the IP layer, pacing sdr_send through udp_tx_enable and udp_tx_active.
// Oversize requests are drained locally so sdr_send never stalls.
// PARAMETERS
// BASE_PORT    16'd1024  source port = BASE_PORT + port_ID
// MAX_PAYLOAD  16'd1472  largest payload forwarded; larger requests are drained, not sent
// PORTS
// tx_clock         in   1   transmit byte clock (single clock domain)
// reset            in   1   asynchronous, active-high reset
// udp_tx_request   in   1   sdr_send wants to send; held until sdr_send returns to IDLE
// udp_tx_length    in   16  payload bytes (excludes UDP header); stable while udp_tx_request is high
// udp_tx_data      in   8   payload byte; sdr_send advances it on each cycle udp_tx_active is high
// port_ID          in   8   source-port offset
// to_port          in   16  destination UDP port (PC port)
// udp_tx_enable    out  1   one-cycle grant; sdr_send loads payload byte 0 on this cycle
// udp_tx_active    out  1   payload byte udp_tx_data consumed this cycle
// ip_tx_request    out  1   request to IP layer
// ip_tx_length     out  16  UDP length = payload + 8; valid while ip_tx_request is high
// ip_tx_enable     in   1   IP layer grant; header bytes start next cycle
// ip_tx_active     in   1   ip_tx_data consumed this cycle
// ip_tx_data       out  8   header byte or payload byte
// len_error        out  1   one-cycle pulse when an oversize request is drained
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; counters 0. Reset mid-packet aborts immediately with no completion.
// - States: IDLE, REQ, HEADER, PAYLOAD, DRAIN, DONE.
// - IDLE: when udp_tx_request=1, latch len=udp_tx_length, src=BASE_PORT+port_ID (16-bit wrap), dst=to_port.
//   - If len>MAX_PAYLOAD, go to DRAIN and pulse udp_tx_enable.
//   - Otherwise go to REQ.
// - REQ: ip_tx_request=1, ip_tx_length=len+8. On ip_tx_enable, pulse udp_tx_enable, clear cnt, go to HEADER.
// - HEADER: ip_tx_data = header byte cnt, in order src[15:8], src[7:0], dst[15:8], dst[7:0],
//   (len+8)[15:8], (len+8)[7:0], 8'h00, 8'h00 (checksum 0).
//   - cnt increments only when ip_tx_active=1.
//   - After byte 7 is consumed: go to PAYLOAD, or to DONE if len=0.
// - PAYLOAD: ip_tx_data = udp_tx_data (combinational); udp_tx_active = ip_tx_active (combinational).
//   - cnt counts consumed bytes. After byte len-1 is consumed, go to DONE.
//   - If udp_tx_request drops mid-payload (sdr_send stuck timeout), drive ip_tx_data=0 and hold
//     udp_tx_active=0 for the remaining bytes. The advertised length is always honoured.
// - DRAIN: udp_tx_active=1 every cycle for len cycles; nothing reaches the IP layer.
//   - Pulse len_error on exit; go to DONE.
// - DONE: ip_tx_request=0. Go to IDLE once udp_tx_request=0, so one request yields one packet.
// - ip_tx_request falls the cycle after the last byte is consumed. udp_tx_active is never high outside
//   PAYLOAD or DRAIN.
// - Back-to-back: a new request while in DONE is not sampled until IDLE (minimum 1 idle cycle).
// TESTING
// - port_ID=11, to_port=1025, len=4, ip_tx_active always 1
//   -> bytes 04 0B 04 01 00 0C 00 00 then 4 payload bytes; ip_tx_length=12.
// - Same packet, ip_tx_active toggling 1010
//   -> identical byte sequence; udp_tx_active high only on active cycles of PAYLOAD.
// - len=0 -> 8 header bytes only; udp_tx_active never asserted; return to IDLE after request drops.
// - len=1500 -> ip_tx_request stays 0; udp_tx_active high for 1500 cycles; one len_error pulse.
// - len=60, udp_tx_request dropped after payload byte 20
//   -> remaining 40 bytes are 00; total 68 bytes sent.
// - reset asserted in HEADER -> all outputs 0 asynchronously; next request produces a complete packet.

Source files
------------

// File: rtl/udp_send.sv
// udp_send: UDP framing stage of the 100 Mbit/s Ethernet transmit path.
//
// Accepts a payload request from sdr_send (length, source-port offset, byte
// stream), prepends the 8-byte UDP header and forwards header + payload to the
// IP layer one byte per ip_tx_active cycle. Payload bytes are pulled from
// sdr_send by pulsing udp_tx_enable once and then asserting udp_tx_active on
// every consumed byte. Oversize requests are drained locally (sdr_send still
// sees its bytes consumed) and flagged with a one-cycle len_error.
//
// Ports
//   tx_clock        in   transmit byte clock
//   reset           in   asynchronous, active-high reset
//   udp_tx_request  in   sdr_send request, held until sdr_send is back in idle
//   udp_tx_length   in   payload length in bytes (excludes UDP header)
//   udp_tx_data     in   current payload byte from sdr_send
//   port_ID         in   source-port offset added to BASE_PORT
//   to_port         in   destination UDP port
//   udp_tx_enable   out  one-cycle grant to sdr_send
//   udp_tx_active   out  payload byte consumed this cycle
//   ip_tx_request   out  request to IP layer
//   ip_tx_length    out  UDP length (payload + 8)
//   ip_tx_enable    in   IP layer grant; header starts next cycle
//   ip_tx_active    in   ip_tx_data consumed this cycle
//   ip_tx_data      out  header or payload byte
//   len_error       out  pulse when an oversize request has been drained
module udp_send #(
    parameter logic [15:0] BASE_PORT   = 16'd1024,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic        tx_clock,
    input  logic        reset,
    input  logic        udp_tx_request,
    input  logic [15:0] udp_tx_length,
    input  logic [7:0]  udp_tx_data,
    input  logic [7:0]  port_ID,
    input  logic [15:0] to_port,
    output logic        udp_tx_enable,
    output logic        udp_tx_active,
    output logic        ip_tx_request,
    output logic [15:0] ip_tx_length,
    input  logic        ip_tx_enable,
    input  logic        ip_tx_active,
    output logic [7:0]  ip_tx_data,
    output logic        len_error
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHeader,
        StPayload,
        StDrain,
        StDone
    } state_e;

    state_e      state;
    logic [15:0] len;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] cnt;
    logic        aborted;   // sdr_send gave up mid-payload; pad the rest with zeros

    logic [15:0] udp_len;
    logic        payload_live;

    assign udp_len      = len + 16'd8;
    // Combinational so the very cycle the request drops is already padded.
    assign payload_live = udp_tx_request && !aborted;

    always_ff @(posedge tx_clock or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            len           <= 16'd0;
            src           <= 16'd0;
            dst           <= 16'd0;
            cnt           <= 16'd0;
            aborted       <= 1'b0;
            udp_tx_enable <= 1'b0;
            ip_tx_request <= 1'b0;
            ip_tx_length  <= 16'd0;
            len_error     <= 1'b0;
        end else begin
            udp_tx_enable <= 1'b0;
            len_error     <= 1'b0;
            case (state)
                StIdle: begin
                    if (udp_tx_request) begin
                        len     <= udp_tx_length;
                        src     <= BASE_PORT + {8'd0, port_ID};
                        dst     <= to_port;
                        cnt     <= 16'd0;
                        aborted <= 1'b0;
                        if (udp_tx_length > MAX_PAYLOAD) begin
                            state         <= StDrain;
                            udp_tx_enable <= 1'b1;
                        end else begin
                            state         <= StReq;
                            ip_tx_request <= 1'b1;
                            ip_tx_length  <= udp_tx_length + 16'd8;
                        end
                    end
                end
                StReq: begin
                    if (ip_tx_enable) begin
                        udp_tx_enable <= 1'b1;
                        cnt           <= 16'd0;
                        state         <= StHeader;
                    end
                end
                StHeader: begin
                    if (ip_tx_active) begin
                        if (cnt == 16'd7) begin
                            cnt <= 16'd0;
                            if (len == 16'd0) begin
                                state         <= StDone;
                                ip_tx_request <= 1'b0;
                            end else begin
                                state <= StPayload;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                StPayload: begin
                    if (!udp_tx_request) begin
                        aborted <= 1'b1;
                    end
                    if (ip_tx_active) begin
                        if (cnt == len - 16'd1) begin
                            cnt           <= 16'd0;
                            state         <= StDone;
                            ip_tx_request <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                StDrain: begin
                    if (cnt == len - 16'd1) begin
                        cnt       <= 16'd0;
                        len_error <= 1'b1;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StDone: begin
                    // Wait for sdr_send to release so one request yields one packet.
                    if (!udp_tx_request) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        udp_tx_active = 1'b0;
        ip_tx_data    = 8'h00;
        case (state)
            StHeader: begin
                case (cnt[2:0])
                    3'd0:    ip_tx_data = src[15:8];
                    3'd1:    ip_tx_data = src[7:0];
                    3'd2:    ip_tx_data = dst[15:8];
                    3'd3:    ip_tx_data = dst[7:0];
                    3'd4:    ip_tx_data = udp_len[15:8];
                    3'd5:    ip_tx_data = udp_len[7:0];
                    default: ip_tx_data = 8'h00;  // checksum unused
                endcase
            end
            StPayload: begin
                if (payload_live) begin
                    ip_tx_data    = udp_tx_data;
                    udp_tx_active = ip_tx_active;
                end
            end
            StDrain: udp_tx_active = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_send.sv
module tb_udp_send;

    localparam logic [15:0] BASE = 16'd1024;

    logic        tx_clock = 1'b0;
    logic        reset;
    logic        udp_tx_request;
    logic [15:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic [7:0]  port_ID;
    logic [15:0] to_port;
    logic        udp_tx_enable;
    logic        udp_tx_active;
    logic        ip_tx_request;
    logic [15:0] ip_tx_length;
    logic        ip_tx_enable;
    logic        ip_tx_active;
    logic [7:0]  ip_tx_data;
    logic        len_error;

    udp_send dut (
        .tx_clock       (tx_clock),
        .reset          (reset),
        .udp_tx_request (udp_tx_request),
        .udp_tx_length  (udp_tx_length),
        .udp_tx_data    (udp_tx_data),
        .port_ID        (port_ID),
        .to_port        (to_port),
        .udp_tx_enable  (udp_tx_enable),
        .udp_tx_active  (udp_tx_active),
        .ip_tx_request  (ip_tx_request),
        .ip_tx_length   (ip_tx_length),
        .ip_tx_enable   (ip_tx_enable),
        .ip_tx_active   (ip_tx_active),
        .ip_tx_data     (ip_tx_data),
        .len_error      (len_error)
    );

    always #5 tx_clock = ~tx_clock;

    typedef struct packed {
        logic [7:0] data;
        logic       act;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] exp_len;
    int          vectors = 0;
    int          miscompares = 0;

    // sdr_send model: byte stream indexed by consumed-byte count
    logic [7:0]  payload [0:2047];
    logic [10:0] pidx = 11'd0;
    logic [10:0] drop_after = 11'd0;
    logic        act_seen = 1'b0;
    assign udp_tx_data = payload[pidx];

    // IP-layer model state
    logic        ip_granted = 1'b0;
    logic        phase = 1'b0;
    int          ip_mode = 0;

    // monitor counters
    logic        drain_mode = 1'b0;
    int          act_cnt = 0;
    int          en_cnt = 0;
    int          lerr_cnt = 0;
    int          ip_req_in_drain = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic next_active(input int mode, input logic ph);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ph;
        return 1'($urandom_range(0, 1));
    endfunction

    // IP layer: grant one cycle after request, then consume per the active pattern
    initial begin
        ip_tx_enable = 1'b0;
        ip_tx_active = 1'b0;
        forever begin
            @(posedge tx_clock);
            #1;
            if (reset) begin
                ip_granted   = 1'b0;
                ip_tx_enable = 1'b0;
                ip_tx_active = 1'b0;
            end else if (ip_tx_enable) begin
                ip_tx_enable = 1'b0;
                ip_granted   = 1'b1;
                phase        = 1'b1;
                ip_tx_active = next_active(ip_mode, phase);
            end else if (ip_granted) begin
                if (!ip_tx_request) begin
                    ip_granted   = 1'b0;
                    ip_tx_active = 1'b0;
                end else begin
                    phase        = ~phase;
                    ip_tx_active = next_active(ip_mode, phase);
                end
            end else if (ip_tx_request) begin
                ip_tx_enable = 1'b1;
            end
        end
    end

    // sdr_send: advance on each consumed byte, optionally give up mid-payload
    initial begin
        forever begin
            @(posedge tx_clock);
            #1;
            if (act_seen && !reset) pidx = pidx + 11'd1;
            if (drop_after != 11'd0 && pidx == drop_after && udp_tx_request)
                udp_tx_request = 1'b0;
        end
    end

    // Monitor / scoreboard
    always @(negedge tx_clock) begin
        if (reset) begin
            act_seen = 1'b0;
        end else begin
            act_seen = udp_tx_active;
            if (udp_tx_enable) en_cnt++;
            if (len_error) lerr_cnt++;
            if (udp_tx_active) act_cnt++;
            if (drain_mode) begin
                if (ip_tx_request) ip_req_in_drain++;
            end else if (ip_granted && ip_tx_request && ip_tx_active) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(ip_tx_data), 32'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("ip_tx_data", 32'(ip_tx_data), 32'(e.data));
                    check("udp_tx_active_byte", 32'(udp_tx_active), 32'(e.act));
                    check("ip_tx_length", 32'(ip_tx_length), 32'(exp_len));
                end
            end else begin
                check("udp_tx_active_idle", 32'(udp_tx_active), 32'd0);
                if (exp_q.size() == 0)
                    check("ip_tx_request_after_last", 32'(ip_tx_request), 32'd0);
            end
        end
    end

    // Reference model: header from the field rules, then payload (zeros after a drop)
    task automatic build_expect(input logic [15:0] len, input logic [7:0] pid,
                                input logic [15:0] dport, input int drop);
        logic [15:0] src;
        logic [15:0] tot;
        logic [63:0] hdr;
        exp_t        it;
        src = BASE + {8'd0, pid};
        tot = len + 16'd8;
        hdr = {src, dport, tot, 16'h0000};
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            it.data = hdr[63 - 8 * k -: 8];
            it.act  = 1'b0;
            exp_q.push_back(it);
        end
        for (int i = 0; i < int'(len); i++) begin
            if (drop == 0 || i < drop) begin
                it.data = payload[i];
                it.act  = 1'b1;
            end else begin
                it.data = 8'h00;
                it.act  = 1'b0;
            end
            exp_q.push_back(it);
        end
        exp_len = tot;
    endtask

    task automatic send_pkt(input logic [15:0] len, input logic [7:0] pid,
                            input logic [15:0] dport, input int mode, input int drop,
                            input int hold);
        logic done;
        int   budget;
        for (int i = 0; i < 2048; i++) payload[i] = 8'($urandom);
        build_expect(len, pid, dport, drop);
        ip_mode    = mode;
        drop_after = 11'(drop);
        pidx       = 11'd0;
        en_cnt     = 0;
        lerr_cnt   = 0;
        @(posedge tx_clock);
        #1;
        port_ID        = pid;
        to_port        = dport;
        udp_tx_length  = len;
        udp_tx_request = 1'b1;
        done   = 1'b0;
        budget = 4 * int'(len) + 100;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge tx_clock);
            #2;
            if (exp_q.size() == 0 && !ip_tx_request) done = 1'b1;
        end
        check("pkt_done", 32'(done), 32'd1);
        // keep the request held a while: no second packet may start
        repeat (hold) @(posedge tx_clock);
        #1;
        udp_tx_request = 1'b0;
        drop_after     = 11'd0;
        repeat (2) @(posedge tx_clock);
        #2;
        check("udp_tx_enable_pulses", 32'(en_cnt), 32'd1);
        check("len_error_pulses", 32'(lerr_cnt), 32'd0);
        if (!done) exp_q.delete();
    endtask

    task automatic drain(input logic [15:0] len);
        int got_err;
        drain_mode      = 1'b1;
        act_cnt         = 0;
        en_cnt          = 0;
        lerr_cnt        = 0;
        ip_req_in_drain = 0;
        @(posedge tx_clock);
        #1;
        port_ID        = 8'($urandom);
        to_port        = 16'($urandom);
        udp_tx_length  = len;
        udp_tx_request = 1'b1;
        got_err = 0;
        for (int c = 0; c < int'(len) + 50 && got_err == 0; c++) begin
            @(posedge tx_clock);
            #2;
            if (lerr_cnt != 0) got_err = 1;
        end
        repeat (3) @(posedge tx_clock);
        #1;
        udp_tx_request = 1'b0;
        repeat (2) @(posedge tx_clock);
        #2;
        check("drain_active_cycles", 32'(act_cnt), 32'(len));
        check("drain_len_error", 32'(lerr_cnt), 32'd1);
        check("drain_enable", 32'(en_cnt), 32'd1);
        check("drain_ip_request", 32'(ip_req_in_drain), 32'd0);
        drain_mode = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_udp_tx_enable"}, 32'(udp_tx_enable), 32'd0);
        check({tag, "_udp_tx_active"}, 32'(udp_tx_active), 32'd0);
        check({tag, "_ip_tx_request"}, 32'(ip_tx_request), 32'd0);
        check({tag, "_ip_tx_length"}, 32'(ip_tx_length), 32'd0);
        check({tag, "_ip_tx_data"}, 32'(ip_tx_data), 32'd0);
        check({tag, "_len_error"}, 32'(len_error), 32'd0);
    endtask

    task automatic reset_in_header();
        int waited;
        for (int i = 0; i < 2048; i++) payload[i] = 8'($urandom);
        build_expect(16'd16, 8'd5, 16'd2000, 0);
        ip_mode = 0;
        pidx    = 11'd0;
        @(posedge tx_clock);
        #1;
        port_ID        = 8'd5;
        to_port        = 16'd2000;
        udp_tx_length  = 16'd16;
        udp_tx_request = 1'b1;
        waited = 0;
        while (exp_q.size() > 16 + 8 - 3 && waited < 50) begin
            @(posedge tx_clock);
            #2;
            waited++;
        end
        check("reach_header", 32'(waited < 50), 32'd1);
        @(posedge tx_clock);
        #3;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        udp_tx_request = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge tx_clock);
        #3;
        reset = 1'b0;
        repeat (2) @(posedge tx_clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        udp_tx_request = 1'b0;
        udp_tx_length  = 16'd0;
        port_ID        = 8'd0;
        to_port        = 16'd0;
        for (int i = 0; i < 2048; i++) payload[i] = 8'h00;
        repeat (3) @(posedge tx_clock);
        #2;
        check_outputs_zero("reset");
        #1;
        reset = 1'b0;

        send_pkt(16'd4, 8'd11, 16'd1025, 0, 0, 0);    // 04 0B 04 01 00 0C 00 00 + 4
        send_pkt(16'd4, 8'd11, 16'd1025, 1, 0, 3);    // 1010 pacing
        send_pkt(16'd0, 8'd7, 16'd80, 0, 0, 4);       // header only
        drain(16'd1500);
        send_pkt(16'd60, 8'd2, 16'd3000, 0, 20, 0);   // sdr_send gives up after 20 bytes
        reset_in_header();
        send_pkt(16'd8, 8'd5, 16'd2000, 0, 0, 1);
        send_pkt(16'd1472, 8'd255, 16'hffff, 0, 0, 0); // largest forwarded payload
        drain(16'd1473);                               // smallest drained payload
        for (int n = 0; n < 12; n++) begin
            send_pkt(16'($urandom_range(0, 64)), 8'($urandom), 16'($urandom),
                     int'($urandom_range(0, 2)), 0, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
